// File: rtl/md5_link_pkg.sv
// Definitions shared by the inbound command path and the outbound response framer.
// Frame headers, payload sizes, framer states and the inbound command-word range.
package md5_link_pkg;

  localparam logic [7:0] HEADER_MATCH = 8'h4D;
  localparam logic [7:0] HEADER_WORD  = 8'h57;
  localparam int         TEXT_BYTES   = 16;
  localparam int         WORD_BYTES   = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HEADER   = 2'd1,
    BODY     = 2'd2,
    CHECKSUM = 2'd3
  } tx_state_e;

  // Inbound command words all fall inside this range.
  localparam logic [31:0] CMD_FIRST = 32'h5230_0000;
  localparam logic [31:0] CMD_LAST  = 32'h5230_3001;

  function automatic logic is_link_cmd(input logic [31:0] word);
    return (word >= CMD_FIRST) && (word <= CMD_LAST);
  endfunction

endpackage

// File: rtl/md5_frame_checksum.sv
// XOR accumulator for the frame trailer: load starts a new frame, acc folds in a byte.
// One-cycle update; load wins over acc.
module md5_frame_checksum (
  input  logic       clk,
  input  logic       resetN,
  input  logic       load_en,
  input  logic       acc_en,
  input  logic [7:0] din,
  output logic [7:0] sum
);

  logic [7:0] sum_q;
  logic [7:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (load_en) begin
      sum_d = din;
    end else if (acc_en) begin
      sum_d = sum_q ^ din;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/md5_response_transmitter.sv
// Frames match events and status words into header/payload/checksum bytes on a valid/ready stream.
// Header appears one edge after a request is latched; 1 byte/clk with txReady high; stalls hold data.
module md5_response_transmitter
  import md5_link_pkg::*;
(
  input  logic         clk,
  input  logic         resetN,
  input  logic         hasMatched,
  input  logic [127:0] text,
  input  logic [31:0]  dataOut,
  input  logic         wordStrobe,
  output logic [7:0]   txData,
  output logic         txValid,
  input  logic         txReady,
  output logic         busy,
  output logic         dropped
);

  tx_state_e    state_q, state_d;
  logic         match_prev_q, match_prev_d;
  logic         match_pend_q, match_pend_d;
  logic         word_pend_q, word_pend_d;
  logic         dropped_q, dropped_d;
  logic         is_match_q, is_match_d;
  logic [127:0] shift_q, shift_d;
  logic [4:0]   idx_q, idx_d;

  logic         handshake;
  logic         select;
  logic         last_byte;
  logic [7:0]   cs_sum;

  assign handshake = txValid && txReady;
  assign select    = (state_q == IDLE) && (match_pend_q || word_pend_q);
  assign last_byte = (idx_q == (is_match_q ? 5'(TEXT_BYTES - 1) : 5'(WORD_BYTES - 1)));

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (match_pend_q || word_pend_q) state_d = HEADER;
      HEADER:   if (handshake) state_d = BODY;
      BODY:     if (handshake && last_byte) state_d = CHECKSUM;
      CHECKSUM: if (handshake) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    txValid = (state_q != IDLE);
    busy    = (state_q != IDLE);
    case (state_q)
      HEADER:   txData = is_match_q ? HEADER_MATCH : HEADER_WORD;
      BODY:     txData = shift_q[7:0];
      CHECKSUM: txData = cs_sum;
      default:  txData = 8'h00;
    endcase
  end

  // Request latching runs in every state; a new request in the cycle its flag clears stays pending.
  always_comb begin
    match_prev_d = hasMatched;
    match_pend_d = match_pend_q;
    word_pend_d  = word_pend_q;
    dropped_d    = dropped_q | (wordStrobe & word_pend_q);
    is_match_d   = is_match_q;
    shift_d      = shift_q;
    idx_d        = idx_q;

    if (select) begin
      is_match_d = match_pend_q;
      shift_d    = match_pend_q ? text : {96'd0, dataOut};
      idx_d      = 5'd0;
      if (match_pend_q) begin
        match_pend_d = 1'b0;
      end else begin
        word_pend_d = 1'b0;
      end
    end

    if (hasMatched && !match_prev_q) match_pend_d = 1'b1;
    if (wordStrobe) word_pend_d = 1'b1;

    if ((state_q == BODY) && handshake) begin
      shift_d = {8'h00, shift_q[127:8]};
      idx_d   = idx_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      match_prev_q <= 1'b0;
      match_pend_q <= 1'b0;
      word_pend_q  <= 1'b0;
      dropped_q    <= 1'b0;
      is_match_q   <= 1'b0;
      shift_q      <= 128'd0;
      idx_q        <= 5'd0;
    end else begin
      match_prev_q <= match_prev_d;
      match_pend_q <= match_pend_d;
      word_pend_q  <= word_pend_d;
      dropped_q    <= dropped_d;
      is_match_q   <= is_match_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
    end
  end

  assign dropped = dropped_q;

  md5_frame_checksum u_checksum (
    .clk     (clk),
    .resetN  (resetN),
    .load_en ((state_q == HEADER) && handshake),
    .acc_en  ((state_q == BODY) && handshake),
    .din     (txData),
    .sum     (cs_sum)
  );

endmodule

// File: tb/tb_md5_response_transmitter.sv
module tb_md5_response_transmitter;

  typedef logic [7:0] bq_t[$];

  logic         clk = 1'b0;
  logic         resetN = 1'b0;
  logic         hasMatched = 1'b0;
  logic [127:0] text = '0;
  logic [31:0]  dataOut = '0;
  logic         wordStrobe = 1'b0;
  logic [7:0]   txData;
  logic         txValid;
  logic         txReady = 1'b1;
  logic         busy;
  logic         dropped;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bq_t got;
  int  stamp[$];

  md5_response_transmitter dut (
    .clk(clk), .resetN(resetN), .hasMatched(hasMatched), .text(text),
    .dataOut(dataOut), .wordStrobe(wordStrobe), .txData(txData),
    .txValid(txValid), .txReady(txReady), .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every byte that will be accepted at the following rising edge.
  always @(negedge clk) begin
    if (resetN && txValid && txReady) begin
      got.push_back(txData);
      stamp.push_back(cyc);
    end
  end

  // Reference frame: header, payload LSB first, XOR of everything before it.
  function automatic bq_t model_frame(input bit m, input logic [127:0] p);
    bq_t q;
    logic [7:0] h, cs;
    int n;
    h = m ? 8'h4D : 8'h57;
    n = m ? 16 : 4;
    q.push_back(h);
    cs = h;
    for (int i = 0; i < n; i++) begin
      q.push_back(p[8*i +: 8]);
      cs = cs ^ p[8*i +: 8];
    end
    q.push_back(cs);
    return q;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    int k;
    ok = 1'b0;
    k = 0;
    while (!ok && k < budget) begin
      @(negedge clk);
      #1;
      if (got.size() >= n) ok = 1'b1;
      k++;
    end
  endtask

  task automatic test_reset;
    #2;
    checks += 4;
    if (txValid !== 1'b0) begin errors++; $display("FAIL reset_txValid got %b want 0", txValid); end
    if (txData !== 8'h00) begin errors++; $display("FAIL reset_txData got %h want 00", txData); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped got %b want 0", dropped); end
    tick; tick;
    resetN = 1'b1;
    tick; tick;
    checks++;
    if (txValid !== 1'b0) begin errors++; $display("FAIL idle_after_reset txValid got %b want 0", txValid); end
  endtask

  task automatic test_match_frame(input logic [127:0] t);
    bq_t exp;
    bit ok;
    got.delete(); stamp.delete();
    text = t;
    exp = model_frame(1'b1, t);
    hasMatched = 1'b1;
    tick; tick;
    hasMatched = 1'b0;
    wait_bytes(18, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL match_timeout got %0d bytes want 18", got.size()); end
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL match_len got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL match_byte%0d got %h want %h", i, got[i], exp[i]); end
    end
    if (stamp.size() == 18) begin
      checks++;
      if (stamp[17] - stamp[0] != 17) begin errors++; $display("FAIL match_throughput span got %0d want 17", stamp[17] - stamp[0]); end
    end
    tick;
    checks++;
    if (busy !== 1'b0 || txValid !== 1'b0) begin errors++; $display("FAIL match_end busy=%b txValid=%b want 0 0", busy, txValid); end
  endtask

  task automatic test_word_frame(input logic [31:0] d);
    bq_t exp;
    bit ok;
    got.delete(); stamp.delete();
    dataOut = d;
    exp = model_frame(1'b0, {96'd0, d});
    wordStrobe = 1'b1;
    tick;
    wordStrobe = 1'b0;
    checks++;
    if (txValid !== 1'b0) begin errors++; $display("FAIL word_latency_early txValid got %b want 0", txValid); end
    tick;
    checks += 2;
    if (txValid !== 1'b1) begin errors++; $display("FAIL word_latency txValid got %b want 1", txValid); end
    if (txData !== 8'h57) begin errors++; $display("FAIL word_header got %h want 57", txData); end
    wait_bytes(6, 100, ok);
    checks++;
    if (!ok || got.size() != 6) begin errors++; $display("FAIL word_len got %0d want 6", got.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL word_byte%0d got %h want %h", i, got[i], exp[i]); end
    end
    tick;
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL word_end busy got %b want 0", busy); end
    if (dropped !== 1'b0) begin errors++; $display("FAIL word_dropped got %b want 0", dropped); end
  endtask

  task automatic test_backpressure;
    bq_t exp;
    bit ok, stalled;
    got.delete(); stamp.delete();
    dataOut = 32'h12345678;
    exp = model_frame(1'b0, {96'd0, 32'h12345678});
    wordStrobe = 1'b1;
    tick;
    wordStrobe = 1'b0;
    stalled = 1'b0;
    for (int k = 0; k < 20 && !stalled; k++) begin
      tick;
      if (txValid && txData == 8'h34) begin
        txReady = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick;
          checks++;
          if (txValid !== 1'b1 || txData !== 8'h34) begin
            errors++; $display("FAIL stall_hold cycle%0d got valid=%b data=%h want 1 34", s, txValid, txData);
          end
        end
        txReady = 1'b1;
        stalled = 1'b1;
      end
    end
    checks++;
    if (!stalled) begin errors++; $display("FAIL stall_reached got no byte 34 want byte 34"); end
    wait_bytes(6, 100, ok);
    checks++;
    if (!ok || got.size() != 6) begin errors++; $display("FAIL stall_len got %0d want 6", got.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL stall_byte%0d got %h want %h", i, got[i], exp[i]); end
    end
    tick; tick;
  endtask

  task automatic test_snapshot;
    bq_t exp;
    bit ok;
    got.delete(); stamp.delete();
    dataOut = 32'h12345678;
    exp = model_frame(1'b0, {96'd0, 32'h12345678});
    wordStrobe = 1'b1;
    tick;
    wordStrobe = 1'b0;
    wait_bytes(1, 50, ok);
    dataOut = 32'hFFFF_FFFF;
    wait_bytes(6, 100, ok);
    checks++;
    if (!ok || got.size() != 6) begin errors++; $display("FAIL snap_len got %0d want 6", got.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL snap_byte%0d got %h want %h", i, got[i], exp[i]); end
    end
    tick; tick;
  endtask

  task automatic test_random_frames;
    bq_t exp;
    bit m;
    int k;
    for (int f = 0; f < 8; f++) begin
      got.delete(); stamp.delete();
      m = 1'($urandom_range(0, 1));
      text = {$urandom, $urandom, $urandom, $urandom};
      dataOut = $urandom;
      exp = m ? model_frame(1'b1, text) : model_frame(1'b0, {96'd0, dataOut});
      if (m) hasMatched = 1'b1; else wordStrobe = 1'b1;
      tick;
      hasMatched = 1'b0;
      wordStrobe = 1'b0;
      k = 0;
      while (got.size() < exp.size() && k < 400) begin
        tick;
        txReady = 1'($urandom_range(0, 1));
        k++;
      end
      txReady = 1'b1;
      checks++;
      if (got.size() != exp.size()) begin errors++; $display("FAIL rand%0d_len got %0d want %0d", f, got.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp[i]) begin errors++; $display("FAIL rand%0d_byte%0d got %h want %h", f, i, got[i], exp[i]); end
      end
      tick; tick;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rand%0d_idle busy got %b want 0", f, busy); end
    end
  endtask

  task automatic test_simultaneous;
    bq_t exp, w;
    logic [127:0] t;
    logic [31:0] d;
    bit ok;
    got.delete(); stamp.delete();
    t = {$urandom, $urandom, $urandom, $urandom};
    d = $urandom;
    text = t;
    dataOut = d;
    exp = model_frame(1'b1, t);
    w = model_frame(1'b0, {96'd0, d});
    foreach (w[i]) exp.push_back(w[i]);
    hasMatched = 1'b1;
    wordStrobe = 1'b1;
    tick;
    wordStrobe = 1'b0;
    tick; tick; tick;
    wordStrobe = 1'b1;
    tick;
    wordStrobe = 1'b0;
    tick;
    wordStrobe = 1'b1;
    tick;
    wordStrobe = 1'b0;
    hasMatched = 1'b0;
    wait_bytes(24, 300, ok);
    for (int i = 0; i < 10; i++) tick;
    checks++;
    if (got.size() != 24) begin errors++; $display("FAIL simul_len got %0d want 24", got.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL simul_byte%0d got %h want %h", i, got[i], exp[i]); end
    end
    if (stamp.size() >= 19) begin
      checks++;
      if (stamp[18] - stamp[17] < 2) begin errors++; $display("FAIL simul_gap got %0d want >=2", stamp[18] - stamp[17]); end
    end
    checks++;
    if (dropped !== 1'b1) begin errors++; $display("FAIL simul_dropped got %b want 1", dropped); end
  endtask

  task automatic test_midframe_reset;
    bq_t exp;
    logic [127:0] t;
    bit ok;
    got.delete(); stamp.delete();
    t = {$urandom, $urandom, $urandom, $urandom};
    text = t;
    exp = model_frame(1'b1, t);
    hasMatched = 1'b1;
    tick;
    wait_bytes(5, 100, ok);
    tick;
    #2;
    resetN = 1'b0;
    #1;
    checks += 4;
    if (txValid !== 1'b0) begin errors++; $display("FAIL rst_txValid got %b want 0", txValid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    if (dropped !== 1'b0) begin errors++; $display("FAIL rst_dropped got %b want 0", dropped); end
    if (txData !== 8'h00) begin errors++; $display("FAIL rst_txData got %h want 00", txData); end
    got.delete(); stamp.delete();
    tick; tick;
    resetN = 1'b1;
    wait_bytes(18, 200, ok);
    checks++;
    if (!ok || got.size() != 18) begin errors++; $display("FAIL rst_len got %0d want 18", got.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL rst_byte%0d got %h want %h", i, got[i], exp[i]); end
    end
    hasMatched = 1'b0;
    tick; tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_end busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset;
    test_match_frame(128'h64636261);
    test_match_frame({$urandom, $urandom, $urandom, $urandom});
    test_word_frame(32'h12345678);
    test_word_frame($urandom);
    test_backpressure;
    test_snapshot;
    test_random_frames;
    test_simultaneous;
    test_midframe_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
